// File: rtl/act_pipe.sv
// act_pipe: two-stage valid/ready activation pipeline (bypass/relu/clip/leaky) with per-lane zero mask
module act_pipe #(
  parameter int LANES = 32,
  parameter int DW = 16,
  parameter int SHW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [LANES*DW-1:0] in_data,
  input  logic [1:0] cfg_mode,
  input  logic [DW-2:0] cfg_clip,
  input  logic [SHW-1:0] cfg_shift,
  output logic out_valid,
  input  logic out_ready,
  output logic [LANES*DW-1:0] out_data,
  output logic [LANES-1:0] out_zero_mask
);
  logic s1_valid, s2_valid, adv;
  logic [LANES*DW-1:0] s1_data, y;
  logic [1:0] s1_mode;
  logic [DW-2:0] s1_clip;
  logic [SHW-1:0] s1_shift;
  logic [LANES-1:0] z;
  logic signed [DW-1:0] clip;
  assign adv = !s2_valid || out_ready;
  assign in_ready = !s1_valid || adv;
  assign out_valid = s2_valid;
  assign clip = {1'b0, s1_clip};
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DW-1:0] x, sh;
    assign x = s1_data[i*DW +: DW];
    assign sh = x >>> s1_shift;
    assign y[i*DW +: DW] = s1_mode == 2'd0 ? x :
                           x < 0 ? (s1_mode == 2'd3 ? sh : {DW{1'b0}}) :
                           (s1_mode == 2'd2 && x > clip) ? clip : x;
    assign z[i] = y[i*DW +: DW] == {DW{1'b0}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_zero_mask <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (adv) s2_valid <= s1_valid;
      if (adv && s1_valid) begin
        out_data <= y;
        out_zero_mask <= z;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_data <= in_data;
      s1_mode <= cfg_mode;
      s1_clip <= cfg_clip;
      s1_shift <= cfg_shift;
    end
  end
endmodule

// File: tb/tb_act_pipe.sv
// tb_act_pipe: directed self-checking bench for act_pipe
module tb_act_pipe;
  localparam int LANES = 32;
  localparam int DW = 16;
  localparam int SHW = 4;
  localparam int W = LANES * DW;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0] cfg_mode;
  logic [DW-2:0] cfg_clip;
  logic [SHW-1:0] cfg_shift;
  logic [LANES-1:0] out_zero_mask;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  act_pipe #(.LANES(LANES), .DW(DW), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_mode(cfg_mode), .cfg_clip(cfg_clip), .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero_mask(out_zero_mask)
  );
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W-1:0] fill(input logic [DW-1:0] f);
    logic [W-1:0] v;
    for (int j = 0; j < LANES; j++) v[j*DW +: DW] = f;
    return v;
  endfunction
  function automatic logic [DW-1:0] act(input logic [DW-1:0] v, input logic [1:0] m, input logic [SHW-1:0] s);
    logic signed [DW-1:0] x;
    x = v;
    case (m)
      2'd0: return v;
      2'd1: return x[DW-1] ? 16'h0 : v;
      2'd2: return x[DW-1] ? 16'h0 : (v > 16'h0100 ? 16'h0100 : v);
      default: begin
        if (!x[DW-1]) return v;
        x = x >>> s;
        return x;
      end
    endcase
  endfunction
  task automatic run_beat(input string tag, input logic [W-1:0] d, input logic [1:0] m,
                          input logic [DW-2:0] c, input logic [SHW-1:0] s,
                          input logic [W-1:0] ed, input logic [LANES-1:0] em);
    in_valid = 1'b1;
    in_data = d;
    cfg_mode = m;
    cfg_clip = c;
    cfg_shift = s;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data = '0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_mask"}, out_zero_mask, em);
    tick();
  endtask
  logic [W-1:0] d, e;
  logic [W-1:0] bd [8];
  logic [W-1:0] exp_d [8];
  logic [LANES-1:0] exp_m [8];
  logic [1:0] pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = fill(16'h1234);
    cfg_mode = 2'd0;
    cfg_clip = '0;
    cfg_shift = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_valid", out_valid, 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", out_data, 0);
    chk("rst_mask", out_zero_mask, 0);
    tick();
    tick();
    chk("rst_no_capture", out_valid, 0);
    for (int j = 0; j < LANES; j++) begin
      d[j*DW +: DW] = j % 2 == 0 ? 16'h8000 : 16'h7FFF;
      e[j*DW +: DW] = j % 2 == 0 ? 16'h0000 : 16'h7FFF;
    end
    run_beat("relu", d, 2'd1, '0, '0, e, 32'h5555_5555);
    d = fill(16'h0001);
    d[0 +: DW] = 16'hFF00;
    d[DW +: DW] = 16'h0050;
    d[2*DW +: DW] = 16'h0100;
    d[3*DW +: DW] = 16'h0200;
    e = fill(16'h0001);
    e[0 +: DW] = 16'h0000;
    e[DW +: DW] = 16'h0050;
    e[2*DW +: DW] = 16'h0100;
    e[3*DW +: DW] = 16'h0100;
    run_beat("clip", d, 2'd2, 15'h0100, '0, e, 32'h1);
    d[0 +: DW] = 16'h7FFF;
    d[DW +: DW] = 16'h8000;
    run_beat("clip0", d, 2'd2, 15'h0000, '0, '0, '1);
    d = fill(16'h0001);
    d[0 +: DW] = 16'hFFF8;
    d[DW +: DW] = 16'hFFFF;
    d[2*DW +: DW] = 16'h0010;
    e = d;
    e[0 +: DW] = 16'hFFFE;
    run_beat("leaky2", d, 2'd3, '0, 4'd2, e, 32'h0);
    run_beat("leaky0", d, 2'd3, '0, 4'd0, d, 32'h0);
    d[0 +: DW] = 16'h8000;
    e = d;
    e[0 +: DW] = 16'hFFFF;
    e[DW +: DW] = 16'hFFFF;
    run_beat("leaky15", d, 2'd3, '0, 4'd15, e, 32'h0);
    d[2*DW +: DW] = 16'h0000;
    e = d;
    run_beat("bypass", d, 2'd0, 15'h0001, 4'd3, e, 32'h4);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < LANES; j++) begin
        bd[k][j*DW +: DW] = j % 2 == 0 ? 16'(-(16 * (k + 1) + j)) : 16'(16'h0200 + j + k);
        exp_d[k][j*DW +: DW] = act(bd[k][j*DW +: DW], 2'(k % 4), 4'(1 + k % 3));
        exp_m[k][j] = exp_d[k][j*DW +: DW] == 16'h0;
      end
    end
    begin
      int sent, got;
      logic prev_stall;
      logic [W-1:0] prev_data;
      sent = 0;
      got = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int t = 0; t < 100 && got < 8; t++) begin
        out_ready = pat[t % 4][0];
        in_valid = sent < 8;
        in_data = sent < 8 ? bd[sent] : '0;
        cfg_mode = 2'(sent % 4);
        cfg_clip = 15'h0100;
        cfg_shift = 4'(1 + sent % 3);
        #1;
        chk("bp_in_ready", in_ready, !(sent - got == 2 && !out_ready));
        if (prev_stall) chk("bp_stable", out_data, prev_data);
        if (out_valid && out_ready) begin
          chk($sformatf("bp_data%0d", got), out_data, exp_d[got]);
          chk($sformatf("bp_mask%0d", got), out_zero_mask, exp_m[got]);
          got++;
        end
        if (in_valid && in_ready) sent++;
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        tick();
      end
      chk("bp_count", got, 8);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = fill(16'h0033);
    cfg_mode = 2'd1;
    tick();
    in_data = fill(16'h0044);
    tick();
    in_valid = 1'b0;
    chk("mid_full_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_flushed", out_valid, 0);
    end
    run_beat("post_rst", fill(16'hFFF0), 2'd1, '0, '0, '0, '1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
